// File: rtl/mult_share_arb_pkg.sv
// Shared defaults and id-width helper for the shared-multiplier arbiter slice.
package mult_share_arb_pkg;

  localparam int unsigned N_DEFAULT        = 16;
  localparam int unsigned NUM_REQ_DEFAULT  = 4;
  localparam int unsigned MULT_LAT_DEFAULT = 3;
  localparam int unsigned ID_W             = $clog2(NUM_REQ_DEFAULT);

  // Width of a requester id; never below one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Rotating-priority arbiter: the search for a valid request starts at ptr.
module rr_arb
  import mult_share_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT,
  parameter int unsigned IW      = id_width(NUM_REQ_DEFAULT)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = IW'((32'(ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_arb.sv
// Shares one pipelined multiplier among NUM_REQ requesters and routes results back by id.
// Define MULT_SHARE_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module mult_share_arb
  import mult_share_arb_pkg::*;
#(
  parameter int unsigned N        = N_DEFAULT,
  parameter int unsigned NUM_REQ  = NUM_REQ_DEFAULT,
  parameter int unsigned MULT_LAT = MULT_LAT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*N-1:0] req_a,
  input  logic [NUM_REQ*N-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [N-1:0]         mul_a,
  output logic [N-1:0]         mul_b,
  input  logic [N-1:0]         mul_y,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [N-1:0]         rsp_y,
  output logic                 busy
);

  localparam int unsigned IW = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]  grant;
  logic [IW-1:0]       ptr;
  logic [IW-1:0]       gid;
  logic                issue;
  logic [MULT_LAT-1:0] tag_v;
  logic [IW-1:0]       tag_id [MULT_LAT];

  rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  assign req_ready = rst ? '0 : grant;
  assign issue     = |req_ready;

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    gid   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        mul_a = req_a[i*N +: N];
        mul_b = req_b[i*N +: N];
        gid   = IW'(i);
      end
    end
  end

`ifdef MULT_SHARE_ARB_FIXED_PRIO_EN
  // A search that always starts at 0 is exactly lowest-index priority.
  assign ptr = '0;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (issue) begin
      ptr <= (gid == IW'(NUM_REQ - 1)) ? '0 : gid + IW'(1);
    end
  end
`endif

  // Tags mirror the multiplier pipeline so each result is steered to its issuer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v <= '0;
      for (int unsigned k = 0; k < MULT_LAT; k++) begin
        tag_id[k] <= '0;
      end
    end else begin
      tag_v[0]  <= issue;
      tag_id[0] <= gid;
      for (int unsigned k = 1; k < MULT_LAT; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_y     = '0;
    if (tag_v[MULT_LAT-1]) begin
      rsp_valid[tag_id[MULT_LAT-1]] = 1'b1;
      rsp_y                         = mul_y;
    end
  end

  assign busy = |tag_v;

endmodule
